count_scheduler: RTL

- Sequences and shares the single count_fsm timing counter between N requesters in the calibration/ranging datapath.
- Each requester asks for a timed count with its own wait_timer. The scheduler arbitrates round-robin and launches count_fsm. It watches busy/flag, captures count_value and returns it to the owner.
- Sits between the ranging/calibration engines and count_fsm.
- Includes an acknowledge watchdog so a stalled counter cannot hang the requesters.

---
 rtl/count_scheduler_pkg.sv | 15 +
 rtl/count_scheduler_if.sv | 28 ++
 rtl/count_scheduler_rr_arbiter.sv | 30 +++
 rtl/count_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/count_scheduler_pkg.sv
// Shared types and defaults for the count_fsm scheduler.
package count_scheduler_pkg;

    localparam int TIMER_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        DONE      = 3'd4
    } sched_state_e;

endpackage

// File: rtl/count_scheduler_if.sv
// Requester bus plus the count_fsm link, shared by the scheduler and its users.
interface count_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int TIMER_W = 8,
    parameter int CNT_W   = 16
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*TIMER_W-1:0] req_timer;
    logic [N_REQ-1:0]         grant;
    logic [N_REQ-1:0]         done;
    logic [CNT_W-1:0]         result_value;
    logic                     result_err;
    logic                     cnt_start;
    logic [TIMER_W-1:0]       cnt_wait_timer;
    logic                     cnt_busy;
    logic                     cnt_flag;
    logic [CNT_W-1:0]         cnt_count_value;

    modport master (
        input  req, req_timer, cnt_busy, cnt_flag, cnt_count_value,
        output grant, done, result_value, result_err, cnt_start, cnt_wait_timer
    );

    modport slave (
        output req, req_timer, cnt_busy, cnt_flag, cnt_count_value,
        input  grant, done, result_value, result_err, cnt_start, cnt_wait_timer
    );
endinterface

// File: rtl/count_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    input  logic                     enable,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] id
);
    localparam int ID_W = $clog2(N_REQ);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (enable && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/count_scheduler.sv
// Round-robin sharing of one count_fsm between N_REQ requesters, with an ack watchdog.
module count_scheduler
    import count_scheduler_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMER_W = TIMER_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ACK_TO  = 4
) (
    input logic              clk,
    input logic              rst_n,
    count_scheduler_if.master bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(ACK_TO + 1);

    sched_state_e       state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [CNT_W-1:0]   result_value_q, result_value_d;
    logic               result_err_q, result_err_d;
    logic               cnt_start_q, cnt_start_d;
    logic [TIMER_W-1:0] cnt_wait_timer_q, cnt_wait_timer_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic [TIMER_W-1:0] sel_timer;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .enable (state_q == IDLE),
        .gnt    (arb_gnt),
        .id     (arb_id)
    );

    always_comb begin
        sel_timer = '0;
        for (int k = 0; k < N_REQ; k++)
            if (arb_id == ID_W'(k)) sel_timer = bus.req_timer[k*TIMER_W +: TIMER_W];
    end

    always_comb begin
        state_d          = state_q;
        id_d             = id_q;
        rr_ptr_d         = rr_ptr_q;
        wdog_d           = wdog_q;
        grant_d          = grant_q;
        done_d           = '0;
        result_value_d   = result_value_q;
        result_err_d     = result_err_q;
        cnt_start_d      = 1'b0;
        cnt_wait_timer_d = cnt_wait_timer_q;

        case (state_q)
            IDLE: if (|bus.req) begin
                id_d             = arb_id;
                grant_d          = arb_gnt;
                cnt_wait_timer_d = sel_timer;
                // A zero timer never touches the counter.
                cnt_start_d      = (sel_timer != '0);
                state_d          = LAUNCH;
            end
            LAUNCH: if (cnt_wait_timer_q == '0) begin
                done_d         = grant_q;
                result_value_d = '0;
                result_err_d   = 1'b0;
                state_d        = DONE;
            end else begin
                wdog_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (bus.cnt_busy) begin
                state_d = RUN;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
                if (wdog_d == WD_W'(ACK_TO)) begin
                    done_d         = grant_q;
                    result_value_d = '0;
                    result_err_d   = 1'b1;
                    state_d        = DONE;
                end
            end
            // Flag and busy-fall together are one completion.
            RUN: if (bus.cnt_flag || !bus.cnt_busy) begin
                done_d         = grant_q;
                result_value_d = bus.cnt_count_value;
                result_err_d   = 1'b0;
                state_d        = DONE;
            end
            DONE: begin
                grant_d  = '0;
                rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            id_q             <= '0;
            rr_ptr_q         <= '0;
            wdog_q           <= '0;
            grant_q          <= '0;
            done_q           <= '0;
            result_value_q   <= '0;
            result_err_q     <= 1'b0;
            cnt_start_q      <= 1'b0;
            cnt_wait_timer_q <= '0;
        end else begin
            state_q          <= state_d;
            id_q             <= id_d;
            rr_ptr_q         <= rr_ptr_d;
            wdog_q           <= wdog_d;
            grant_q          <= grant_d;
            done_q           <= done_d;
            result_value_q   <= result_value_d;
            result_err_q     <= result_err_d;
            cnt_start_q      <= cnt_start_d;
            cnt_wait_timer_q <= cnt_wait_timer_d;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.done           = done_q;
    assign bus.result_value   = result_value_q;
    assign bus.result_err     = result_err_q;
    assign bus.cnt_start      = cnt_start_q;
    assign bus.cnt_wait_timer = cnt_wait_timer_q;
endmodule
